// File: rtl/ibex_testrig_pkg.sv
// Shared types for the TestRIG local-memory arbiter.
//   mem_port_e : which core port owns a grant/response
//   mem_rsp_t  : one-entry response pipe payload
package ibex_testrig_pkg;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } mem_port_e;

  typedef struct packed {
    logic      valid;
    mem_port_e port;
    logic      is_write;
    logic      err;
  } mem_rsp_t;

  // Bit position of the CHERIoT capability tag within a 33-bit word
  localparam int unsigned TAG_BIT = 32;
  localparam int unsigned WORD_W  = 33;

endpackage

// File: rtl/ibex_testrig_rr_arb2.sv
// Two-way round-robin arbiter between the fetch and data ports.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_req_instr/i_req_data : requests
//   o_gnt_instr/o_gnt_data : combinational one-hot (or zero) grants
// The loser of the previous conflict wins the next one; single requesters
// are granted directly and do not disturb the history.
module ibex_testrig_rr_arb2
  import ibex_testrig_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_instr,
  input  logic i_req_data,
  output logic o_gnt_instr,
  output logic o_gnt_data
);

  mem_port_e r_last_winner;
  logic      w_conflict;

  // Grant selection; nothing is granted while reset is held
  always_comb begin
    o_gnt_instr = 1'b0;
    o_gnt_data  = 1'b0;
    w_conflict  = i_req_instr & i_req_data;
    if (!i_rst) begin
      if (w_conflict) begin
        if (r_last_winner == PORT_INSTR) begin
          o_gnt_data = 1'b1;
        end else begin
          o_gnt_instr = 1'b1;
        end
      end else begin
        o_gnt_instr = i_req_instr;
        o_gnt_data  = i_req_data;
      end
    end
  end

  // History only moves on conflict cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_winner <= PORT_INSTR;
    end else if (w_conflict) begin
      r_last_winner <= o_gnt_data ? PORT_DATA : PORT_INSTR;
    end
  end

endmodule

// File: rtl/ibex_testrig_mem_arb.sv
// Arbitrates Ibex fetch and data ports onto one single-port 33-bit tagged SRAM.
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   instr_*                  : fetch port (req/gnt/rvalid/addr/rdata/err)
//   data_*                   : data port (req/gnt/rvalid/we/be/addr/wdata/rdata/err)
//   ram_*                    : SRAM side, read data returns one cycle after req
//   conflict_cnt_o           : saturating count of cycles with both requests high
// Grants and SRAM strobes are combinational from the requests; responses come
// from a one-entry register so a new grant can overlap the previous response.
module ibex_testrig_mem_arb
  import ibex_testrig_pkg::*;
#(
  parameter int unsigned Depth    = 16384,
  parameter logic [31:0] BaseAddr = 32'h8000_0000,
  localparam int unsigned AddrW   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             instr_req_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  input  logic [31:0]      instr_addr_i,
  output logic [32:0]      instr_rdata_o,
  output logic             instr_err_o,

  input  logic             data_req_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [32:0]      data_wdata_i,
  output logic [32:0]      data_rdata_o,
  output logic             data_err_o,

  output logic             ram_req_o,
  output logic             ram_we_o,
  output logic [4:0]       ram_be_o,
  output logic [AddrW-1:0] ram_addr_o,
  output logic [32:0]      ram_wdata_o,
  input  logic [32:0]      ram_rdata_i,

  output logic [15:0]      conflict_cnt_o
);

  localparam logic [31:0] MemBytes = 32'(Depth * 4);

  logic        w_gnt_instr;
  logic        w_gnt_data;
  logic        w_gnt_any;
  logic [31:0] w_addr;
  logic [31:0] w_off;
  logic        w_in_range;
  logic        w_ram_req;
  logic        w_rsp_live;
  logic [32:0] w_rsp_rdata;
  mem_rsp_t    w_rsp_d;
  mem_rsp_t    r_rsp;
  logic [15:0] r_conflict_cnt;

  ibex_testrig_rr_arb2 u_arb (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_req_instr (instr_req_i),
    .i_req_data  (data_req_i),
    .o_gnt_instr (w_gnt_instr),
    .o_gnt_data  (w_gnt_data)
  );

  assign instr_gnt_o = w_gnt_instr;
  assign data_gnt_o  = w_gnt_data;
  assign w_gnt_any   = w_gnt_instr | w_gnt_data;

  // Decode the granted port's address; offset wraps so below-base is out of range
  assign w_addr     = w_gnt_data ? data_addr_i : instr_addr_i;
  assign w_off      = w_addr - BaseAddr;
  assign w_in_range = (w_off < MemBytes);
  assign w_ram_req  = w_gnt_any & w_in_range;

  // SRAM strobes; all zero when no in-range access is granted
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 5'h00;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (w_ram_req) begin
      ram_req_o  = 1'b1;
      ram_addr_o = w_off[AddrW+1:2];
      if (w_gnt_data && data_we_i) begin
        ram_we_o    = 1'b1;
        ram_be_o    = {1'b1, data_be_i};
        // Tag survives only a full-word write; any partial write clears it
        ram_wdata_o = {data_wdata_i[TAG_BIT] & (data_be_i == 4'hF), data_wdata_i[31:0]};
      end else begin
        ram_be_o = 5'h1F;
      end
    end
  end

  // Response payload for this cycle's grant
  always_comb begin
    w_rsp_d          = '0;
    w_rsp_d.valid    = w_gnt_any;
    w_rsp_d.port     = w_gnt_data ? PORT_DATA : PORT_INSTR;
    w_rsp_d.is_write = w_gnt_data & data_we_i;
    w_rsp_d.err      = ~w_in_range;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp <= '0;
    end else begin
      r_rsp <= w_rsp_d;
    end
  end

  // Suppress a response that would otherwise surface during reset
  assign w_rsp_live  = r_rsp.valid & ~rst_i;
  assign w_rsp_rdata = (w_rsp_live && !r_rsp.is_write && !r_rsp.err) ? ram_rdata_i : '0;

  assign instr_rvalid_o = w_rsp_live & (r_rsp.port == PORT_INSTR);
  assign data_rvalid_o  = w_rsp_live & (r_rsp.port == PORT_DATA);
  assign instr_err_o    = instr_rvalid_o & r_rsp.err;
  assign data_err_o     = data_rvalid_o & r_rsp.err;
  assign instr_rdata_o  = instr_rvalid_o ? w_rsp_rdata : '0;
  assign data_rdata_o   = data_rvalid_o ? w_rsp_rdata : '0;

  // Saturating conflict counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_conflict_cnt <= 16'h0000;
    end else if (instr_req_i && data_req_i && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_ibex_testrig_mem_arb.sv
// Self-checking bench for ibex_testrig_mem_arb with a cycle-level reference model.
module tb_ibex_testrig_mem_arb;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int unsigned MEM_BYTES = 65536;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_i = 1'b0;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i = '0;
  logic [32:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [32:0] data_wdata_i = '0;
  logic [32:0] data_rdata_o;
  logic        data_err_o;
  logic        ram_req_o;
  logic        ram_we_o;
  logic [4:0]  ram_be_o;
  logic [13:0] ram_addr_o;
  logic [32:0] ram_wdata_o;
  logic [32:0] ram_rdata_i = '0;
  logic [15:0] conflict_cnt_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_last_data;
  int          m_cnt;
  bit          p_valid, p_data, p_err, p_read;
  bit          e_gi, e_gd, e_req, e_we, e_in;
  logic [13:0] e_addr;
  logic [4:0]  e_be;
  logic [32:0] e_wdata;
  logic [31:0] m_a;

  ibex_testrig_mem_arb dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_req_i    (instr_req_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_addr_i   (instr_addr_i),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .ram_req_o      (ram_req_o),
    .ram_we_o       (ram_we_o),
    .ram_be_o       (ram_be_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_rdata_i    (ram_rdata_i),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < MEM_BYTES;
  endfunction

  // Expected combinational behaviour for the inputs currently applied
  task automatic model_comb();
    e_gi = 1'b0;
    e_gd = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
        if (m_last_data) e_gi = 1'b1;
        else             e_gd = 1'b1;
      end else begin
        e_gi = instr_req_i;
        e_gd = data_req_i;
      end
    end
    m_a     = e_gd ? data_addr_i : instr_addr_i;
    e_in    = in_rng(m_a);
    e_req   = (e_gi || e_gd) && e_in;
    e_addr  = 14'((m_a - BASE) / 4);
    e_we    = e_gd && data_we_i;
    e_be    = e_we ? {1'b1, data_be_i} : 5'h1F;
    e_wdata = {data_wdata_i[32] && (data_be_i == 4'hF), data_wdata_i[31:0]};
  endtask

  // Model state update at the clock edge
  task automatic model_commit();
    if (rst_i) begin
      m_last_data = 1'b0;
      m_cnt       = 0;
      p_valid     = 1'b0;
    end else begin
      if (instr_req_i && data_req_i) begin
        m_last_data = e_gd;
        if (m_cnt < 65535) m_cnt++;
      end
      p_valid = e_gi || e_gd;
      p_data  = e_gd;
      p_err   = !e_in;
      p_read  = !e_we;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_comb();
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    data_we_i   = 1'b0;
    data_be_i   = 4'h0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b want 000000",
               {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o});
    end
    checks++;
    if ({ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_ram: got req=%b we=%b be=%h addr=%h wdata=%h want all 0",
               ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o);
    end
    checks++;
    if ({instr_rdata_o, data_rdata_o} !== 66'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", instr_rdata_o, data_rdata_o);
    end
    checks++;
    if (conflict_cnt_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h want 0000", conflict_cnt_o);
    end
  endtask

  task automatic test_instr_read();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h8000_0010;
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o, ram_req_o, ram_we_o, ram_be_o, ram_addr_o} !== {4'b1010, 5'h1F, 14'd4}) begin
      errors++;
      $display("FAIL instr_read_req: got gnt=%b%b req=%b we=%b be=%h addr=%0d want 10 1 0 1f 4",
               instr_gnt_o, data_gnt_o, ram_req_o, ram_we_o, ram_be_o, ram_addr_o);
    end
    tick();
    instr_req_i = 1'b0;
    ram_rdata_i = 33'h1_DEAD_BEEF;
    #1;
    checks++;
    if ({instr_rvalid_o, instr_err_o, data_rvalid_o, instr_rdata_o} !== {3'b100, 33'h1_DEAD_BEEF}) begin
      errors++;
      $display("FAIL instr_read_rsp: got rvalid=%b err=%b drv=%b rdata=%h want 1 0 0 1deadbeef",
               instr_rvalid_o, instr_err_o, data_rvalid_o, instr_rdata_o);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic [3:0] seq_d;
    seq_d = 4'b0101;  // data, instr, data, instr
    apply_reset();
    instr_req_i  = 1'b1;
    instr_addr_i = BASE + 32'h100;
    data_req_i   = 1'b1;
    data_we_i    = 1'b0;
    data_addr_i  = BASE + 32'h200;
    for (int k = 0; k < 4; k++) begin
      ram_rdata_i = {1'($urandom), 32'($urandom)};
      #1;
      checks++;
      if ({data_gnt_o, instr_gnt_o} !== {seq_d[k], ~seq_d[k]}) begin
        errors++;
        $display("FAIL conflict_gnt[%0d]: got d=%b i=%b want d=%b", k, data_gnt_o, instr_gnt_o, seq_d[k]);
      end
      if (k > 0) begin
        checks++;
        if ({data_rvalid_o, instr_rvalid_o} !== {seq_d[k-1], ~seq_d[k-1]}) begin
          errors++;
          $display("FAIL conflict_rvalid[%0d]: got d=%b i=%b want d=%b", k, data_rvalid_o, instr_rvalid_o, seq_d[k-1]);
        end
      end
      tick();
    end
    idle_inputs();
    ram_rdata_i = 33'h0_1234_5678;
    #1;
    checks++;
    if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== {2'b10, 33'h0_1234_5678}) begin
      errors++;
      $display("FAIL conflict_last_rsp: got i=%b d=%b rdata=%h want 1 0 012345678",
               instr_rvalid_o, data_rvalid_o, instr_rdata_o);
    end
    checks++;
    if (conflict_cnt_o !== 16'd4) begin
      errors++;
      $display("FAIL conflict_cnt: got %0d want 4", conflict_cnt_o);
    end
    tick();
  endtask

  task automatic test_partial_write();
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'h3;
    data_addr_i  = BASE + 32'h20;
    data_wdata_i = 33'h1_0000_1234;
    #1;
    checks++;
    if ({data_gnt_o, ram_req_o, ram_we_o, ram_be_o, ram_wdata_o} !== {3'b111, 5'h13, 33'h0_0000_1234}) begin
      errors++;
      $display("FAIL partial_write: got gnt=%b req=%b we=%b be=%h wdata=%h want 1 1 1 13 000001234",
               data_gnt_o, ram_req_o, ram_we_o, ram_be_o, ram_wdata_o);
    end
    tick();
    data_be_i   = 4'hF;
    ram_rdata_i = 33'h1_FFFF_FFFF;
    #1;
    checks++;
    if ({ram_be_o, ram_wdata_o, ram_addr_o} !== {5'h1F, 33'h1_0000_1234, 14'd8}) begin
      errors++;
      $display("FAIL full_write: got be=%h wdata=%h addr=%0d want 1f 100001234 8", ram_be_o, ram_wdata_o, ram_addr_o);
    end
    checks++;
    if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 33'h0}) begin
      errors++;
      $display("FAIL write_rsp: got rvalid=%b err=%b rdata=%h want 1 0 0", data_rvalid_o, data_err_o, data_rdata_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [2];
    addrs[0] = 32'h7FFF_FFFC;
    addrs[1] = 32'h8001_0000;
    for (int k = 0; k < 2; k++) begin
      data_req_i  = 1'b1;
      data_we_i   = 1'b0;
      data_addr_i = addrs[k];
      #1;
      checks++;
      if ({data_gnt_o, ram_req_o} !== 2'b10) begin
        errors++;
        $display("FAIL oor_req[%h]: got gnt=%b ram_req=%b want 1 0", addrs[k], data_gnt_o, ram_req_o);
      end
      tick();
      data_req_i  = 1'b0;
      ram_rdata_i = 33'h1_5A5A_A5A5;
      #1;
      checks++;
      if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b11, 33'h0}) begin
        errors++;
        $display("FAIL oor_rsp[%h]: got rvalid=%b err=%b rdata=%h want 1 1 0",
                 addrs[k], data_rvalid_o, data_err_o, data_rdata_o);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    instr_req_i  = 1'b1;
    instr_addr_i = BASE;
    data_req_i   = 1'b1;
    data_addr_i  = BASE + 32'h4;
    #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_first: got data_gnt=%b want 1", data_gnt_o);
    end
    tick();
    rst_i = 1'b1;
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o, ram_req_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_in_reset: got gnt=%b%b req=%b rvalid=%b%b want all 0",
               instr_gnt_o, data_gnt_o, ram_req_o, instr_rvalid_o, data_rvalid_o);
    end
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({instr_rvalid_o, data_rvalid_o, conflict_cnt_o} !== {2'b00, 16'h0}) begin
      errors++;
      $display("FAIL rstmid_after: got rvalid=%b%b cnt=%0d want 00 0", instr_rvalid_o, data_rvalid_o, conflict_cnt_o);
    end
    checks++;
    if ({data_gnt_o, instr_gnt_o} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_regrant: got d=%b i=%b want d=1 i=0", data_gnt_o, instr_gnt_o);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic        exp_irv, exp_drv;
    logic [32:0] exp_rdata;
    for (int n = 0; n < 400; n++) begin
      instr_req_i  = 1'($urandom);
      data_req_i   = 1'($urandom);
      instr_addr_i = ($urandom_range(7) == 0) ? 32'($urandom) : BASE + 32'($urandom_range(MEM_BYTES - 1));
      data_addr_i  = ($urandom_range(7) == 0) ? 32'($urandom) : BASE + 32'($urandom_range(MEM_BYTES - 1));
      data_we_i    = 1'($urandom);
      data_be_i    = 4'($urandom);
      data_wdata_i = {1'($urandom), 32'($urandom)};
      ram_rdata_i  = {1'($urandom), 32'($urandom)};
      #1;
      model_comb();
      exp_irv   = p_valid && !p_data;
      exp_drv   = p_valid && p_data;
      exp_rdata = (p_read && !p_err) ? ram_rdata_i : 33'h0;
      checks++;
      if ({instr_gnt_o, data_gnt_o, ram_req_o} !== {e_gi, e_gd, e_req}) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: got gi=%b gd=%b req=%b want %b %b %b",
                 n, instr_gnt_o, data_gnt_o, ram_req_o, e_gi, e_gd, e_req);
      end
      if (e_req) begin
        checks++;
        if ({ram_addr_o, ram_we_o, ram_be_o} !== {e_addr, e_we, e_be}) begin
          errors++;
          $display("FAIL rand_ram[%0d]: got addr=%h we=%b be=%h want %h %b %h",
                   n, ram_addr_o, ram_we_o, ram_be_o, e_addr, e_we, e_be);
        end
        if (e_we) begin
          checks++;
          if (ram_wdata_o !== e_wdata) begin
            errors++;
            $display("FAIL rand_wdata[%0d]: got %h want %h", n, ram_wdata_o, e_wdata);
          end
        end
      end
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {exp_irv, exp_drv}) begin
        errors++;
        $display("FAIL rand_rvalid[%0d]: got i=%b d=%b want i=%b d=%b",
                 n, instr_rvalid_o, data_rvalid_o, exp_irv, exp_drv);
      end
      if (p_valid) begin
        checks++;
        if (p_data ? ({data_rdata_o, data_err_o} !== {exp_rdata, p_err})
                   : ({instr_rdata_o, instr_err_o} !== {exp_rdata, p_err})) begin
          errors++;
          $display("FAIL rand_rsp[%0d]: got irdata=%h ierr=%b drdata=%h derr=%b want rdata=%h err=%b",
                   n, instr_rdata_o, instr_err_o, data_rdata_o, data_err_o, exp_rdata, p_err);
        end
      end
      checks++;
      if (conflict_cnt_o !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, conflict_cnt_o, m_cnt);
      end
      @(posedge clk_i);
      model_commit();
      #1;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    instr_req_i  = 1'b1;
    data_req_i   = 1'b1;
    instr_addr_i = BASE;
    data_addr_i  = BASE + 32'h8;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (i == 65533) begin
        checks++;
        if (conflict_cnt_o !== 16'hFFFE) begin
          errors++;
          $display("FAIL sat_near: got %h want fffe", conflict_cnt_o);
        end
      end
      if (i == 65534) begin
        checks++;
        if (conflict_cnt_o !== 16'hFFFF) begin
          errors++;
          $display("FAIL sat_reach: got %h want ffff", conflict_cnt_o);
        end
      end
    end
    checks++;
    if (conflict_cnt_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h want ffff", conflict_cnt_o);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_conflict();
    test_partial_write();
    test_out_of_range();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_testrig_mem_arb.md
Name: ibex_testrig_mem_arb

Overview:
- Arbitrates the core's instruction-fetch and data ports onto one single-port tagged SRAM (33-bit words: bit 32 is the CHERIoT capability tag).
- Used in the TestRIG/SRAM top-level so the core can run from local memory instead of the simulation environment.
- Generates `gnt`/`rvalid`/`err` for both ports, with fixed 1-cycle read latency, and enforces tag-clearing on partial writes.
- Counts arbitration conflicts.

Parameters:
- Depth, 16384: SRAM depth in 33-bit words (64 KiB data).
- BaseAddr, 32'h8000_0000: byte address of SRAM word 0.
- AddrW, $clog2(Depth): derived SRAM word-address width; not overridable.

Ports:
- clk_i in 1: clock
- rst_i in 1: synchronous, active-high reset
- instr_req_i in 1: fetch request
- instr_gnt_o out 1: fetch granted
- instr_rvalid_o out 1: fetch response valid
- instr_addr_i in 32: fetch byte address
- instr_rdata_o out 33: fetch data, including tag
- instr_err_o out 1: fetch error (qualified by rvalid)
- data_req_i in 1: data request
- data_gnt_o out 1: data granted
- data_rvalid_o out 1: data response valid
- data_we_i in 1: write enable
- data_be_i in 4: byte enables
- data_addr_i in 32: data byte address
- data_wdata_i in 33: write data, bit 32 = tag
- data_rdata_o out 33: read data
- data_err_o out 1: data error (qualified by rvalid)
- ram_req_o out 1: SRAM access
- ram_we_o out 1: SRAM write
- ram_be_o out 5: SRAM byte enables; bit 4 = tag-bit enable
- ram_addr_o out AddrW: SRAM word address
- ram_wdata_o out 33: SRAM write data
- ram_rdata_i in 33: SRAM read data, valid the cycle after a read
- conflict_cnt_o out 16: saturating count of cycles with both requests asserted

Behaviour:
- Reset values: all `gnt`/`rvalid`/`err`/`ram_*` outputs 0; rdata outputs 0; conflict_cnt_o 0; last_winner = INSTR.
- Grant path is combinational from the requests; at most one grant per cycle.
  - Single requester: that requester is granted.
  - Both requesting: grant the port that is not last_winner (round-robin). last_winner updates only on conflict cycles.
  - After reset, the first conflict goes to DATA.
- Address decode: off = addr − BaseAddr (32-bit unsigned, wraps).
  - in_range = off < Depth*4.
  - ram_addr_o = off[AddrW+1:2]; addr[1:0] is ignored.
- Granted in-range access:
  - ram_req_o=1 in the same cycle.
  - Fetches use ram_we_o=0 and ram_be_o=5'h1F.
- Data writes:
  - ram_be_o[3:0] = data_be_i; ram_be_o[4] = 1.
  - ram_wdata_o[31:0] = data_wdata_i[31:0].
  - ram_wdata_o[32] = data_wdata_i[32] & (data_be_i == 4'hF). Partial writes always clear the tag.
- Granted out-of-range access: ram_req_o=0; the response carries err=1 and rdata=0.
- Response pipeline: a 1-entry register holds {valid, port, is_write, err}.
  - Exactly 1 cycle after a grant, the matching rvalid is 1 for one cycle.
  - rdata = ram_rdata_i for an in-range read; 0 for writes and errors.
  - Full throughput: a new grant may occur in the same cycle as the previous response.
- Requests held without a grant remain pending; nothing is dropped. Requesters may change address while ungranted.
- conflict_cnt_o increments on every cycle where both requests are high and saturates at 16'hFFFF.
- Reset mid-operation: the response register clears, so no rvalid is issued for the grant in the reset cycle. No ram_req_o is asserted while rst_i=1.

Decomposition:
- Shared package (ibex_testrig_pkg):
  - `mem_port_e` {PORT_INSTR, PORT_DATA}
  - `mem_rsp_t` struct {valid, port, is_write, err}
  - TAG_BIT = 32 constant
- One sub-module, ibex_testrig_rr_arb2: 2-way round-robin grant plus last_winner flop.
- Decode and the response pipe stay in the top.

Test Plan:
- Instr-only read at 32'h8000_0010 with ram_rdata_i=33'h1_DEAD_BEEF → grant cycle 0, ram_addr_o=4, instr_rvalid_o in cycle 1 with rdata 33'h1_DEAD_BEEF, err 0.
- Both requests held for 4 cycles after reset → grants D,I,D,I; conflict_cnt_o=4; each rvalid lands 1 cycle after its grant.
- Data write be=4'h3, wdata=33'h1_0000_1234 → ram_be_o=5'h13, ram_wdata_o[32]=0. Then be=4'hF with the same data → ram_wdata_o[32]=1.
- data_addr 32'h7FFF_FFFC and 32'h8001_0000 (Depth=16384) → gnt, no ram_req_o, rvalid with err=1 and rdata=0.
- rst_i asserted in the cycle after a grant → no rvalid, conflict_cnt_o=0, next conflict grants DATA.
- Hold both requests for 70000 cycles → conflict_cnt_o saturates at 16'hFFFF.
